// File: rtl/gcd_lcm_coprocessor.sv
// GCD/LCM coprocessor sitting behind the single-cycle RISC-V core.
// Takes the core's Start level and WDFinal word, runs a subtractive Euclid
// loop, optionally followed by a multiply and a restoring divide for LCM,
// and returns a status/result word on ans_data (done at bit 8).
//
// Handshake (4-phase, level based): the core raises start with op_data valid;
// the launch edge is the first rising edge in IDLE with start=1, and op_data
// is sampled only there. done rises when the result is ready and stays high
// while start stays high; the core then drops start and done falls on the
// next edge. A new launch needs start low for at least one edge, which the
// DONE->IDLE transition guarantees.
module gcd_lcm_coprocessor #(
    parameter int DIV_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_data,
    output logic [31:0] ans_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GCD  = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    // FSM state is a plain named register so checkers can bind to it.
    logic [2:0]       state;
    logic [7:0]       a0;
    logic [7:0]       b0;
    logic             opr;
    logic [7:0]       x;
    logic [7:0]       y;
    logic [7:0]       g;
    logic [15:0]      prod;
    logic [7:0]       rem;
    logic [15:0]      quo;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      result;
    logic             done;
    logic             ovf;
    logic             zop;

    // Operand decode of the core's write-data word.
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_op;
    assign in_a  = op_data[7:0];
    assign in_b  = op_data[15:8];
    assign in_op = op_data[16];

    // One restoring-divide step: shift in the next dividend bit, trial-subtract g.
    // rem stays below g (<=255), so the shifted value fits in 9 bits.
    logic [8:0]  rem_sh;
    logic        rem_ge;
    logic [8:0]  rem_nxt;
    logic [15:0] quo_nxt;
    always_comb begin
        rem_sh  = {rem, prod[15]};
        rem_ge  = (rem_sh >= {1'b0, g});
        rem_nxt = rem_ge ? (rem_sh - {1'b0, g}) : rem_sh;
        quo_nxt = {quo[14:0], rem_ge};
    end

    // Bits that are architecturally don't-care: op_data[31:17], the 9th
    // remainder bit (always 0 after the trial subtract) and the quotient bit
    // shifted out of the top.
    logic unused_bits;
    assign unused_bits = ^{op_data[31:17], rem_nxt[8], quo[15]};

    // Main control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            a0     <= 8'h0;
            b0     <= 8'h0;
            opr    <= 1'b0;
            x      <= 8'h0;
            y      <= 8'h0;
            g      <= 8'h0;
            prod   <= 16'h0;
            rem    <= 8'h0;
            quo    <= 16'h0;
            cnt    <= '0;
            result <= 16'h0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            zop    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a0   <= in_a;
                        b0   <= in_b;
                        opr  <= in_op;
                        x    <= in_a;
                        y    <= in_b;
                        done <= 1'b0;
                        ovf  <= 1'b0;
                        if (in_a == 8'h0 || in_b == 8'h0) begin
                            // GCD(0,n)=n, GCD(0,0)=0; LCM with a zero operand is 0.
                            zop    <= 1'b1;
                            result <= in_op ? 16'h0 : {8'h0, in_a | in_b};
                            state  <= S_DONE;
                        end else begin
                            zop    <= 1'b0;
                            result <= 16'h0;
                            state  <= S_GCD;
                        end
                    end
                end
                S_GCD: begin
                    if (x > y) begin
                        x <= x - y;
                    end else if (y > x) begin
                        y <= y - x;
                    end else begin
                        g <= x;
                        if (opr) begin
                            state <= S_MUL;
                        end else begin
                            result <= {8'h0, x};
                            ovf    <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    prod  <= {8'h0, a0} * {8'h0, b0};
                    rem   <= 8'h0;
                    quo   <= 16'h0;
                    cnt   <= CNT_W'(DIV_STEPS);
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem  <= rem_nxt[7:0];
                    quo  <= quo_nxt;
                    prod <= {prod[14:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        result <= quo_nxt;
                        ovf    <= (quo_nxt[15:8] != 8'h0);
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The zero-operand shortcut arrives with done still low;
                    // raise it first so the core always sees it before release.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status word is built purely from registers; no path from the inputs.
    assign ans_data = {result, 5'b0, zop, ovf, done, result[7:0]};

endmodule

// File: doc/gcd_lcm_coprocessor.md
Name: gcd_lcm_coprocessor

Overview:
- Multi-cycle GCD/LCM engine directly downstream of the single-cycle RISC-V core.
- Consumes the core's Start strobe and final write-data word (operands plus opcode select).
- Runs a subtractive Euclid loop, then optionally a multiply and restoring divide.
- Returns a status/result word to the core's AnsData input, with done at bit 8.

Parameters:
- DIV_STEPS, 16, iterations of the restoring divider; must equal the product width (2 x 8 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request level from core (core's Start); 4-phase handshake
- op_data  input  32  operand word (core's WDFinal): [7:0]=A, [15:8]=B, [16]=op (0=GCD, 1=LCM), [31:17] ignored
- ans_data  output  32  status/result (to core's AnsData), bit fields below

ans_data fields:
- [7:0]: result low byte
- [8]: done
- [9]: overflow (result > 255)
- [10]: zero_op (A or B was 0)
- [15:11]: 0
- [31:16]: full 16-bit result

Behaviour:
- Reset (async, immediate): state=IDLE; all internal registers=0; ans_data=32'h0. Reset mid-operation aborts with no residue.
- States: IDLE, GCD, MUL, DIV, DONE.
- IDLE:
  - On a clock edge with start=1: latch A, B, op into a0/b0/opr and working regs x=A, y=B.
  - Clear the done/overflow/zero_op result register.
  - If A==0 or B==0, go to DONE directly:
    - GCD result = A|B (GCD(0,0)=0); LCM result = 0.
    - zero_op=1.
  - Otherwise go to GCD.
- GCD: one step per cycle.
  - x>y: x<=x-y.
  - y>x: y<=y-x.
  - x==y: g=x. op=GCD → DONE with result={8'h0,g}. op=LCM → MUL.
- MUL (1 cycle): prod <= a0*b0 (16-bit); rem<=0; quo<=0; cnt<=DIV_STEPS; → DIV.
- DIV: restoring division of prod by g, MSB first, one quotient bit per cycle.
  - Shift rem left, bringing in the next prod bit.
  - If rem>=g, subtract g and set the quotient bit to 1.
  - After DIV_STEPS cycles, go to DONE; result=quo (exact, since g divides a0*b0).
- DONE:
  - ans_data shows result; done=1; overflow=(result[15:8]!=0); zero_op as latched.
  - Stays in DONE while start=1.
  - On an edge with start=0, go to IDLE; done clears that edge.
  - [31:16], [7:0], [9], [10] keep the last result until the next launch.
- Start behaviour:
  - start is ignored in GCD/MUL/DIV.
  - A start still held high through DONE must not relaunch; a new launch needs start low for ≥1 edge first.
- op_data is sampled only at the launch edge; later changes have no effect.
- Latency, counted in edges after the launch edge until done=1:
  - GCD: N+1, where N = subtraction steps.
  - LCM: N+1+1+DIV_STEPS.
  - Zero operand: 1.
- ans_data is registered only; there is no combinational path from inputs.

Test Plan:
- Reset: assert reset asynchronously mid-cycle → ans_data=0 immediately; state IDLE; no done.
- GCD: op_data=A=12, B=18, op=0, start held → steps (12,18)→(12,6)→(6,6); done at 3rd edge after launch; ans_data[7:0]=6, [31:16]=6, [9]=0.
- LCM: A=12, B=18, op=1 → done 20 edges after launch; result 36 (ans_data=32'h0024_0124).
- LCM overflow: A=255, B=254 → [31:16]=16'hFD02, [7:0]=8'h02, [9]=1.
- Zero operand: A=0, B=9, op=0 → done 1 edge after launch, result 9, [10]=1. Same operands with op=1 → result 0.
- Handshake and abort:
  - Keep start high after done for 5 cycles → no relaunch, result stable.
  - Drop start → done falls next edge.
  - Change op_data mid-run → no effect.
  - Pulse reset during DIV → ans_data=0; a subsequent launch gives correct results.
